// File: rtl/passive_pkg.sv
// rtl/passive_pkg.sv - shared types and defaults for the passive chime controller
package passive_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_BEEP_ON  = 3'd2,
    ST_BEEP_OFF = 3'd3,
    ST_SILENCED = 3'd4,
    ST_TIMEOUT  = 3'd5
  } state_t;

  localparam int DEF_DEBOUNCE_CYC = 4;
  localparam int DEF_ON_CYC       = 8;
  localparam int DEF_OFF_CYC      = 8;
  localparam int DEF_MAX_BEEPS    = 5;
  localparam int DEF_CNT_W        = 16;

  function automatic int beep_w(input int max_beeps);
    return $clog2(max_beeps + 1);
  endfunction

endpackage

// File: rtl/passive_timer.sv
// rtl/passive_timer.sv - loadable down-counter with clear and expiry flag
module passive_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Flags the edge on which the current phase ends.
  assign o_done = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/passive_chime_ctrl.sv
// rtl/passive_chime_ctrl.sv - debounced buzzer/lamp alert for the passive warning
module passive_chime_ctrl
  import passive_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int ON_CYC       = DEF_ON_CYC,
  parameter int OFF_CYC      = DEF_OFF_CYC,
  parameter int MAX_BEEPS    = DEF_MAX_BEEPS,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          PassiveSignal,
  input  logic                          DriverAck,
  output logic                          Buzzer,
  output logic                          WarningLamp,
  output logic                          TimeoutFlag,
  output logic [beep_w(MAX_BEEPS)-1:0]  BeepCount
);

  localparam int BW = beep_w(MAX_BEEPS);
  localparam logic [BW-1:0]    MAX_B  = BW'(MAX_BEEPS);
  localparam logic [CNT_W-1:0] DB_LD  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] ON_LD  = CNT_W'(ON_CYC);
  localparam logic [CNT_W-1:0] OFF_LD = CNT_W'(OFF_CYC);

  state_t           r_state, w_next;
  logic [BW-1:0]    r_beep;
  logic             r_buzzer, r_lamp, r_timeout;
  logic             w_ld, w_en, w_clr, w_done, w_beep_inc, w_beep_clr;
  logic [CNT_W-1:0] w_ld_val;

  passive_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (w_clr),
    .i_load     (w_ld),
    .i_load_val (w_ld_val),
    .i_en       (w_en),
    .o_done     (w_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_ld       = 1'b0;
    w_ld_val   = '0;
    w_en       = 1'b0;
    w_clr      = 1'b0;
    w_beep_inc = 1'b0;
    w_beep_clr = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_beep_clr = 1'b1;
        if (PassiveSignal) begin
          w_ld = 1'b1;
          if (DEBOUNCE_CYC == 1) begin
            w_next   = ST_BEEP_ON;
            w_ld_val = ON_LD;
          end else begin
            w_next   = ST_DEBOUNCE;
            w_ld_val = DB_LD;
          end
        end else begin
          w_clr = 1'b1;
        end
      end
      ST_DEBOUNCE: begin
        if (!PassiveSignal) begin
          w_next = ST_IDLE;
          w_clr  = 1'b1;
        end else if (w_done) begin
          w_next   = ST_BEEP_ON;
          w_ld     = 1'b1;
          w_ld_val = ON_LD;
        end else begin
          w_en = 1'b1;
        end
      end
      ST_BEEP_ON: begin
        if (!PassiveSignal) begin
          w_next     = ST_IDLE;
          w_clr      = 1'b1;
          w_beep_clr = 1'b1;
        end else begin
          // A beep that finishes on the silencing edge still counts.
          w_beep_inc = w_done;
          if (DriverAck) begin
            w_next = ST_SILENCED;
            w_clr  = 1'b1;
          end else if (w_done) begin
            w_next   = ST_BEEP_OFF;
            w_ld     = 1'b1;
            w_ld_val = OFF_LD;
          end else begin
            w_en = 1'b1;
          end
        end
      end
      ST_BEEP_OFF: begin
        if (!PassiveSignal) begin
          w_next     = ST_IDLE;
          w_clr      = 1'b1;
          w_beep_clr = 1'b1;
        end else if (DriverAck) begin
          w_next = ST_SILENCED;
          w_clr  = 1'b1;
        end else if (w_done) begin
          if (r_beep == MAX_B) begin
            w_next = ST_TIMEOUT;
            w_clr  = 1'b1;
          end else begin
            w_next   = ST_BEEP_ON;
            w_ld     = 1'b1;
            w_ld_val = ON_LD;
          end
        end else begin
          w_en = 1'b1;
        end
      end
      ST_SILENCED, ST_TIMEOUT: begin
        w_clr = 1'b1;
        if (!PassiveSignal) begin
          w_next     = ST_IDLE;
          w_beep_clr = 1'b1;
        end
      end
      default: begin
        w_next     = ST_IDLE;
        w_clr      = 1'b1;
        w_beep_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || w_beep_clr) begin
      r_beep <= '0;
    end else if (w_beep_inc && (r_beep != MAX_B)) begin
      r_beep <= r_beep + BW'(1);
    end
  end

  // Outputs are registered from the next state so they move on the same edge as the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_buzzer  <= 1'b0;
      r_lamp    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_buzzer  <= (w_next == ST_BEEP_ON);
      r_lamp    <= (w_next != ST_IDLE) && (w_next != ST_DEBOUNCE);
      r_timeout <= (w_next == ST_TIMEOUT);
    end
  end

  assign Buzzer      = r_buzzer;
  assign WarningLamp = r_lamp;
  assign TimeoutFlag = r_timeout;
  assign BeepCount   = r_beep;

endmodule

// File: tb/tb_passive_chime_ctrl.sv
// tb/tb_passive_chime_ctrl.sv - scoreboard bench for passive_chime_ctrl
module tb_passive_chime_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       PassiveSignal = 1'b0;
  logic       DriverAck = 1'b0;
  logic       Buzzer, WarningLamp, TimeoutFlag;
  logic [2:0] BeepCount;

  passive_chime_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .PassiveSignal (PassiveSignal),
    .DriverAck     (DriverAck),
    .Buzzer        (Buzzer),
    .WarningLamp   (WarningLamp),
    .TimeoutFlag   (TimeoutFlag),
    .BeepCount     (BeepCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         n;
    string      tag;
    logic       buz;
    logic       lamp;
    logic       tf;
    logic [2:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n = 0;
  int   checks = 0;
  int   errors = 0;
  bit   done = 0;

  task automatic step(input logic r, input logic p, input logic a);
    @(negedge clk);
    reset = r;
    PassiveSignal = p;
    DriverAck = a;
    @(posedge clk);
    n++;
  endtask

  task automatic expect_out(input string tag, input logic b, input logic l, input logic t, input int c);
    exp_t e;
    e.n = n; e.tag = tag; e.buz = b; e.lamp = l; e.tf = t; e.cnt = 3'(c);
    q.push_back(e);
  endtask

  // Expected pattern j cycles after the alert started (defaults: 8 on, 8 off, 5 beeps).
  function automatic logic exp_buz(input int j);
    return (j < 80) && ((j % 16) < 8);
  endfunction

  function automatic int exp_cnt(input int j);
    if (j >= 80) return 5;
    return (j / 16) + (((j % 16) >= 8) ? 1 : 0);
  endfunction

  task automatic run_alert(input string tag, input int jmax);
    for (int i = 1; i <= 3; i++) begin
      step(1'b0, 1'b1, 1'b0);
      expect_out({tag, "_db"}, 1'b0, 1'b0, 1'b0, 0);
    end
    for (int j = 0; j <= jmax; j++) begin
      step(1'b0, 1'b1, 1'b0);
      expect_out(tag, exp_buz(j), 1'b1, (j >= 80), exp_cnt(j));
    end
  endtask

  task automatic idle_steps(input string tag, input int k);
    for (int i = 0; i < k; i++) begin
      step(1'b0, 1'b0, 1'b0);
      expect_out(tag, 1'b0, 1'b0, 1'b0, 0);
    end
  endtask

  always @(negedge clk) begin
    while (q.size() != 0 && q[0].n <= n) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (e.n != n) begin
        errors++;
        $display("FAIL %s edge %0d: sample missed (now edge %0d)", e.tag, e.n, n);
      end else if (Buzzer !== e.buz || WarningLamp !== e.lamp ||
                   TimeoutFlag !== e.tf || BeepCount !== e.cnt) begin
        errors++;
        $display("FAIL %s edge %0d: got buz=%b lamp=%b tf=%b cnt=%0d, want buz=%b lamp=%b tf=%b cnt=%0d",
                 e.tag, n, Buzzer, WarningLamp, TimeoutFlag, BeepCount,
                 e.buz, e.lamp, e.tf, e.cnt);
      end
    end
  end

  initial begin
    // Reset state
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    expect_out("reset", 1'b0, 1'b0, 1'b0, 0);
    idle_steps("idle", 2);

    // Clean alert through timeout, hold, release
    run_alert("clean", 84);
    step(1'b0, 1'b1, 1'b1);
    expect_out("timeout_ack_ignored", 1'b0, 1'b1, 1'b1, 5);
    step(1'b0, 1'b0, 1'b0);
    expect_out("clean_release", 1'b0, 1'b0, 1'b0, 0);
    idle_steps("clean_idle", 1);

    // Glitch: three high edges then low
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0);
      expect_out("glitch_hi", 1'b0, 1'b0, 1'b0, 0);
    end
    idle_steps("glitch_lo", 3);

    // Silence during beep 2 ON
    run_alert("silence", 17);
    step(1'b0, 1'b1, 1'b1);
    expect_out("silence_ack", 1'b0, 1'b1, 1'b0, 1);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b0);
      expect_out("silence_hold", 1'b0, 1'b1, 1'b0, 1);
    end
    idle_steps("silence_release", 2);

    // Ack on the edge that ends beep 1 ON: silenced, beep still counted
    run_alert("coinc", 7);
    step(1'b0, 1'b1, 1'b1);
    expect_out("coinc_ack", 1'b0, 1'b1, 1'b0, 1);
    step(1'b0, 1'b1, 1'b0);
    expect_out("coinc_hold", 1'b0, 1'b1, 1'b0, 1);
    idle_steps("coinc_release", 1);

    // Abort in BEEP_OFF of beep 3, then full re-debounce
    run_alert("abort", 42);
    step(1'b0, 1'b0, 1'b0);
    expect_out("abort_drop", 1'b0, 1'b0, 1'b0, 0);
    run_alert("rearm", 1);
    idle_steps("rearm_release", 1);

    // Tie: drop and ack on the same edge in BEEP_ON
    run_alert("tie", 3);
    step(1'b0, 1'b0, 1'b1);
    expect_out("tie_edge", 1'b0, 1'b0, 1'b0, 0);
    idle_steps("tie_idle", 1);

    // Reset during beep 4 ON with PassiveSignal held high
    run_alert("rst", 50);
    step(1'b1, 1'b1, 1'b0);
    expect_out("rst_edge", 1'b0, 1'b0, 1'b0, 0);
    run_alert("rst_fresh", 20);
    idle_steps("rst_release", 1);

    repeat (3) @(negedge clk);
    done = 1;
  end

  initial begin
    int budget;
    budget = 0;
    while (!done && budget < 5000) begin
      @(posedge clk);
      budget++;
    end
    repeat (2) @(posedge clk);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout: stimulus still running after %0d cycles, want completion", budget);
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/passive_chime_ctrl.md
# passive_chime_ctrl

Receiving end of the car passive-security warning. Consumes the passive warning (lights on, door open, ignition off) and turns it into a driver-facing alert: it debounces the request, drives a timed on/off buzzer pattern plus a steady warning lamp, and supports driver silencing and an automatic beep-count timeout. It sits between the passive-security detector output and the cabin buzzer/lamp drivers.

## Interface
Parameters:
- DEBOUNCE_CYC, 4: consecutive sampled-high edges required before alerting (≥1).
- ON_CYC, 8: buzzer-high cycles per beep (≥1).
- OFF_CYC, 8: buzzer-low cycles between beeps (≥1).
- MAX_BEEPS, 5: beeps before automatic timeout (≥1).
- CNT_W, 16: phase-timer width; must hold max(DEBOUNCE_CYC, ON_CYC, OFF_CYC).

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; one clock, synchronous active-high reset.
- PassiveSignal  in  1  warning request from the passive-security detector.
- DriverAck  in  1  driver silence request; level, sampled each edge.
- Buzzer  out  1  buzzer drive, registered.
- WarningLamp  out  1  dashboard lamp, registered.
- TimeoutFlag  out  1  high while in TIMEOUT.
- BeepCount  out  $clog2(MAX_BEEPS+1)  completed beeps in current episode.

## Operation
- Moore FSM, states IDLE, DEBOUNCE, BEEP_ON, BEEP_OFF, SILENCED, TIMEOUT; all outputs decoded from registered state/counters.
- Reset: state IDLE, timer 0, BeepCount 0; Buzzer, WarningLamp, TimeoutFlag all 0.
- IDLE: PassiveSignal=1 → DEBOUNCE, debounce count=1.
- DEBOUNCE: PassiveSignal=0 → IDLE (count cleared); count reaching DEBOUNCE_CYC → BEEP_ON, timer loaded.
- BEEP_ON: Buzzer=1, Lamp=1; after ON_CYC cycles → BEEP_OFF, BeepCount+1.
- BEEP_OFF: Buzzer=0, Lamp=1; after OFF_CYC cycles → TIMEOUT if BeepCount==MAX_BEEPS, else BEEP_ON.
- SILENCED: Buzzer=0, Lamp=1; held until PassiveSignal=0.
- TIMEOUT: Buzzer=0, Lamp=1, TimeoutFlag=1; held until PassiveSignal=0.
- Per-edge priority: reset > PassiveSignal=0 (any non-IDLE state → IDLE, BeepCount cleared) > DriverAck=1 (BEEP_ON/BEEP_OFF → SILENCED) > timer expiry.
- DriverAck ignored in IDLE, DEBOUNCE, SILENCED, TIMEOUT; no pending latch.
- BeepCount saturates at MAX_BEEPS; frozen in SILENCED/TIMEOUT; cleared on return to IDLE.
- New episode only after passing through IDLE (PassiveSignal must drop).

## Timing
- Buzzer and Lamp rise on the edge where PassiveSignal is sampled high for the DEBOUNCE_CYC-th consecutive edge (defaults: high on edges 1–4 → outputs 1 after edge 4).
- Buzzer high exactly ON_CYC cycles, low exactly OFF_CYC cycles; period ON_CYC+OFF_CYC.
- TIMEOUT entered MAX_BEEPS·(ON_CYC+OFF_CYC) cycles after alert start (defaults: 80).
- PassiveSignal low sampled at edge n → all outputs 0 after edge n (1-cycle latency).
- DriverAck sampled at edge n in BEEP_ON → Buzzer 0 after edge n, Lamp stays 1.
- Simultaneous PassiveSignal=0 and DriverAck=1 → IDLE.
- Timer expiry coincident with DriverAck → SILENCED; BeepCount still increments if expiry ended a BEEP_ON.
- Reset mid-beep → IDLE next edge, outputs 0, no residual count.

## Structure
- Package passive_pkg: state enum type, default parameter constants, BeepCount width function.
- One sub-module: passive_timer — loadable CNT_W-bit down-counter with load value, enable, synchronous clear, done pulse; shared by debounce and beep phases.

## Test plan
- Clean alert: PassiveSignal high 4 edges → Buzzer 1 after edge 4; 8 high / 8 low; BeepCount 1..5; TimeoutFlag 1 after 80 cycles, Lamp 1, Buzzer 0.
- Glitch: PassiveSignal high 3 edges then low → no output ever asserts; state IDLE.
- Silence: DriverAck pulse during beep 2 (BEEP_ON) → Buzzer 0 next edge, Lamp 1, BeepCount frozen at 1; PassiveSignal low → all 0.
- Abort: PassiveSignal drops during BEEP_OFF of beep 3 → all outputs 0 and BeepCount 0 next edge; re-raise requires full 4-edge debounce.
- Tie: PassiveSignal 0 and DriverAck 1 same edge in BEEP_ON → IDLE, all outputs 0.
- Reset mid-BEEP_ON at beep 4 → outputs 0, BeepCount 0 after the reset edge; PassiveSignal still high → fresh debounce then beep 1.
